// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory region controller: FSM states,
// default region map and address-decode helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    WAIT_RDY = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam int REG_SDRAM = 0;
  localparam int REG_FLASH = 1;
  localparam int REG_SRAM  = 2;
  localparam int REG_REGS  = 3;

  // Helpers work on a fixed 32-region ceiling; callers narrow the result.
  localparam int MAX_NR = 32;

  function automatic logic [MAX_NR-1:0] onehot(input logic [4:0] idx);
    logic [MAX_NR-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [4:0] rgn_index(input logic [63:0] addr, input int aw, input int rsel_w);
    logic [63:0] s;
    s = addr >> (aw - rsel_w);
    return 5'(s & ((64'd1 << rsel_w) - 64'd1));
  endfunction

endpackage

// File: rtl/mem_ws_timer.sv
// Wait-state down-counter and bus-timeout up-counter for one access.
// TO_W must be at least 2.
module mem_ws_timer #(
  parameter int WS_W = 4,
  parameter int TO_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ws_load,
  input  logic [WS_W-1:0] ws_val,
  input  logic            ws_dec,
  input  logic            to_clr,
  input  logic            to_inc,
  output logic            ws_done,
  output logic            timeout
);

  // Terminal count is the cycle in which the counter would reach all-ones,
  // so WAIT_RDY lasts 2**TO_W-1 cycles before the error is raised.
  localparam logic [TO_W-1:0] TO_TERM = {{(TO_W-1){1'b1}}, 1'b0};

  logic [WS_W-1:0] ws_cnt_q, ws_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign ws_done = (ws_cnt_q == '0);
  assign timeout = (to_cnt_q == TO_TERM);

  always_comb begin
    ws_cnt_d = ws_cnt_q;
    if (ws_load) begin
      ws_cnt_d = ws_val;
    end else if (ws_dec && !ws_done) begin
      ws_cnt_d = ws_cnt_q - WS_W'(1);
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (to_clr) begin
      to_cnt_d = '0;
    end else if (to_inc) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ws_cnt_q <= '0;
      to_cnt_q <= '0;
    end else begin
      ws_cnt_q <= ws_cnt_d;
      to_cnt_q <= to_cnt_d;
    end
  end

endmodule

// File: rtl/mem_region_ctrl.sv
// CPU bus to N back-end region decoder with per-region wait states,
// back-end ready handshake, bus timeout and single-cycle ack/err.
module mem_region_ctrl
  import mem_pkg::*;
#(
  parameter int AW     = 24,
  parameter int DW     = 16,
  parameter int RSEL_W = 2,
  parameter int WS_W   = 4,
  parameter int TO_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [DW/8-1:0]          cpu_be,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  output logic [DW-1:0]            cpu_rdata,
  output logic                     cpu_ack,
  output logic                     cpu_err,
  input  logic [(2**RSEL_W)-1:0]   rgn_en,
  input  logic [(2**RSEL_W)*WS_W-1:0] ws_cfg,
  output logic [(2**RSEL_W)-1:0]   rgn_sel,
  output logic                     rgn_we,
  output logic [DW/8-1:0]          rgn_be,
  output logic [AW-RSEL_W-1:0]     rgn_addr,
  output logic [DW-1:0]            rgn_wdata,
  input  logic [(2**RSEL_W)*DW-1:0] rgn_rdata,
  input  logic [(2**RSEL_W)-1:0]   rgn_rdy
);

  localparam int NR = 2**RSEL_W;
  localparam int BW = DW/8;
  localparam int OW = AW-RSEL_W;

  state_e          state_q, state_d;
  logic [RSEL_W-1:0] idx_q, idx_d;
  logic [NR-1:0]   sel_q, sel_d;
  logic            we_q, we_d;
  logic [BW-1:0]   be_q, be_d;
  logic [OW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            err_pend_q, err_pend_d;

  logic [RSEL_W-1:0] cpu_idx;
  logic [DW-1:0]   rd_lane [NR];
  logic [WS_W-1:0] ws_lane [NR];

  logic ws_load, ws_dec, to_clr, to_inc;
  logic ws_done, timeout;

  assign cpu_idx = RSEL_W'(rgn_index(64'(cpu_addr), AW, RSEL_W));

  for (genvar gi = 0; gi < NR; gi++) begin : g_lane
    assign rd_lane[gi] = rgn_rdata[gi*DW +: DW];
    assign ws_lane[gi] = ws_cfg[gi*WS_W +: WS_W];
  end

  mem_ws_timer #(
    .WS_W (WS_W),
    .TO_W (TO_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .ws_load (ws_load),
    .ws_val  (ws_lane[cpu_idx]),
    .ws_dec  (ws_dec),
    .to_clr  (to_clr),
    .to_inc  (to_inc),
    .ws_done (ws_done),
    .timeout (timeout)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sel_d      = sel_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_pend_d = err_pend_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    ws_load    = 1'b0;
    ws_dec     = 1'b0;
    to_clr     = 1'b0;
    to_inc     = 1'b0;
    case (state_q)
      IDLE: begin
        // The ack cycle itself is not a new request; a still-high req is
        // only taken one cycle later, guaranteeing a gap between acks.
        if (cpu_req && !ack_q) begin
          if (rgn_en[cpu_idx]) begin
            idx_d      = cpu_idx;
            sel_d      = NR'(onehot(5'(cpu_idx)));
            we_d       = cpu_we;
            be_d       = cpu_be;
            addr_d     = cpu_addr[OW-1:0];
            wdata_d    = cpu_wdata;
            err_pend_d = 1'b0;
            ws_load    = 1'b1;
            state_d    = ACCESS;
          end else begin
            err_pend_d = 1'b1;
            rdata_d    = '0;
            state_d    = DONE;
          end
        end
      end
      ACCESS: begin
        if (ws_done) begin
          to_clr  = 1'b1;
          state_d = WAIT_RDY;
        end else begin
          ws_dec = 1'b1;
        end
      end
      WAIT_RDY: begin
        if (rgn_rdy[idx_q]) begin
          rdata_d    = rd_lane[idx_q];
          err_pend_d = 1'b0;
          state_d    = DONE;
        end else if (timeout) begin
          rdata_d    = '0;
          err_pend_d = 1'b1;
          state_d    = DONE;
        end else begin
          to_inc = 1'b1;
        end
      end
      DONE: begin
        ack_d   = 1'b1;
        err_d   = err_pend_q;
        sel_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign rgn_sel   = sel_q;
  assign rgn_we    = we_q;
  assign rgn_be    = be_q;
  assign rgn_addr  = addr_q;
  assign rgn_wdata = wdata_q;

endmodule

// File: tb/tb_mem_region_ctrl.sv
// Directed bench for mem_region_ctrl: scoreboard of expected acks checked
// by a negedge monitor, plus inline checks of the region-side outputs.
module tb_mem_region_ctrl;
  import mem_pkg::*;

  localparam int AW = 24, DW = 16, RSEL_W = 2, WS_W = 4, TO_W = 4, NR = 4;

  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_we;
  logic [1:0]  cpu_be;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic cpu_ack, cpu_err;
  logic [3:0]  rgn_en;
  logic [15:0] ws_cfg;
  logic [3:0]  rgn_sel;
  logic rgn_we;
  logic [1:0]  rgn_be;
  logic [21:0] rgn_addr;
  logic [15:0] rgn_wdata;
  logic [63:0] rgn_rdata;
  logic [3:0]  rgn_rdy;

  mem_region_ctrl #(.AW(AW), .DW(DW), .RSEL_W(RSEL_W), .WS_W(WS_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .rgn_en(rgn_en), .ws_cfg(ws_cfg),
    .rgn_sel(rgn_sel), .rgn_we(rgn_we), .rgn_be(rgn_be), .rgn_addr(rgn_addr),
    .rgn_wdata(rgn_wdata), .rgn_rdata(rgn_rdata), .rgn_rdy(rgn_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          issue;
    int          lat;
    logic        err;
    logic        chk_rd;
    logic [15:0] rd;
    logic        chk_addr;
    logic [21:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_ack = 1'b0;
  logic got, sel_any;

  localparam logic [15:0] LANE_SDRAM = 16'h1111, LANE_FLASH = 16'h2222;
  localparam logic [15:0] LANE_SRAM  = 16'hA5C3, LANE_REGS  = 16'h7E81;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int iss, input int lat, input logic err, input logic chk_rd,
                          input logic [15:0] rd, input logic chk_addr, input logic [21:0] addr);
    exp_t t;
    t.issue = iss; t.lat = lat; t.err = err; t.chk_rd = chk_rd;
    t.rd = rd; t.chk_addr = chk_addr; t.addr = addr;
    sb.push_back(t);
  endtask

  task automatic issue(input logic we, input logic [1:0] be, input logic [23:0] addr,
                       input logic [15:0] wd, input int lat, input logic err,
                       input logic chk_rd, input logic [15:0] rd, input logic chk_addr);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
    push_exp(cyc + 1, lat, err, chk_rd, rd, chk_addr, addr[21:0]);
  endtask

  task automatic wait_ack(input int budget, output logic g, output logic s);
    g = 1'b0; s = 1'b0;
    for (int i = 0; i < budget && !g; i++) begin
      @(negedge clk);
      if (rgn_sel != 4'b0) s = 1'b1;
      if (cpu_ack) g = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_ack) begin
        chk("ack_single_cycle", {31'b0, prev_ack}, 32'd0);
        chk("ack_expected", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("ack_latency", cyc - mon_e.issue, mon_e.lat);
          chk("ack_err", {31'b0, cpu_err}, {31'b0, mon_e.err});
          if (mon_e.chk_rd) chk("ack_rdata", {16'b0, cpu_rdata}, {16'b0, mon_e.rd});
          if (mon_e.chk_addr) chk("ack_rgn_addr", {10'b0, rgn_addr}, {10'b0, mon_e.addr});
        end
      end else begin
        chk("err_without_ack", {31'b0, cpu_err}, 32'd0);
      end
      prev_ack = cpu_ack;
    end else begin
      prev_ack = 1'b0;
    end
  end

  initial begin
    rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_be = 0; cpu_addr = 0; cpu_wdata = 0;
    rgn_en = 4'b1101;
    ws_cfg = {4'd0, 4'd3, 4'd5, 4'd0};
    rgn_rdata = {LANE_REGS, LANE_SRAM, LANE_FLASH, LANE_SDRAM};
    rgn_rdy = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", {31'b0, cpu_ack}, 0);
    chk("rst_err", {31'b0, cpu_err}, 0);
    chk("rst_rdata", {16'b0, cpu_rdata}, 0);
    chk("rst_sel", {28'b0, rgn_sel}, 0);
    chk("rst_we_be", {29'b0, rgn_we, rgn_be}, 0);
    chk("rst_addr_wdata", {10'b0, rgn_addr} | {16'b0, rgn_wdata}, 0);

    // 1: SRAM read with 3 wait states
    issue(1'b0, 2'b11, 24'h800010, 16'h0, 6, 1'b0, 1'b1, LANE_SRAM, 1'b1);
    @(negedge clk);
    chk("t1_sel", {28'b0, rgn_sel}, 32'h4);
    chk("t1_addr", {10'b0, rgn_addr}, 32'h10);
    wait_ack(40, got, sel_any); cpu_req = 1'b0;
    chk("t1_got_ack", {31'b0, got}, 1);

    // 2: SDRAM write, zero wait states; bus changes after acceptance ignored
    issue(1'b1, 2'b10, 24'h000004, 16'hBEEF, 3, 1'b0, 1'b0, 16'h0, 1'b1);
    @(negedge clk);
    cpu_addr = 24'h800000; cpu_wdata = 16'h0000;
    chk("t2_sel", {28'b0, rgn_sel}, 32'h1);
    chk("t2_we_be", {29'b0, rgn_we, rgn_be}, 32'h6);
    chk("t2_wdata", {16'b0, rgn_wdata}, 32'hBEEF);
    wait_ack(40, got, sel_any); cpu_req = 1'b0;
    chk("t2_got_ack", {31'b0, got}, 1);
    chk("t2_wdata_held", {16'b0, rgn_wdata}, 32'hBEEF);

    // 3: disabled FLASH region
    issue(1'b0, 2'b11, 24'h400000, 16'h0, 1, 1'b1, 1'b0, 16'h0, 1'b0);
    wait_ack(40, got, sel_any); cpu_req = 1'b0;
    chk("t3_got_ack", {31'b0, got}, 1);
    chk("t3_sel_never", {31'b0, sel_any}, 0);

    // 4a: REGS ready never arrives -> timeout
    rgn_rdy[REG_REGS] = 1'b0;
    issue(1'b0, 2'b11, 24'hC00000, 16'h0, 17, 1'b1, 1'b1, 16'h0, 1'b1);
    wait_ack(60, got, sel_any); cpu_req = 1'b0;
    chk("t4a_got_ack", {31'b0, got}, 1);

    // 4b: ready rises exactly on the terminal WAIT_RDY cycle
    issue(1'b0, 2'b11, 24'hC00000, 16'h0, 17, 1'b0, 1'b1, LANE_REGS, 1'b1);
    repeat (16) @(negedge clk);
    rgn_rdy[REG_REGS] = 1'b1;
    wait_ack(60, got, sel_any); cpu_req = 1'b0;
    chk("t4b_got_ack", {31'b0, got}, 1);

    // 5: reset during WAIT_RDY aborts without ack, then a clean access
    rgn_rdy[REG_REGS] = 1'b0;
    issue(1'b0, 2'b11, 24'hC00008, 16'h0, 3, 1'b0, 1'b1, LANE_REGS, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("t5_sel_after_rst", {28'b0, rgn_sel}, 0);
    chk("t5_ack_after_rst", {31'b0, cpu_ack}, 0);
    wait_ack(4, got, sel_any);
    chk("t5_no_ack", {31'b0, got}, 0);
    rgn_rdy[REG_REGS] = 1'b1;
    issue(1'b0, 2'b11, 24'hC00008, 16'h0, 3, 1'b0, 1'b1, LANE_REGS, 1'b1);
    wait_ack(40, got, sel_any); cpu_req = 1'b0;
    chk("t5_got_ack", {31'b0, got}, 1);

    // 6: req held across two accesses; second uses the re-accepted address
    issue(1'b0, 2'b11, 24'h800020, 16'h0, 6, 1'b0, 1'b1, LANE_SRAM, 1'b1);
    wait_ack(40, got, sel_any);
    chk("t6_got_ack1", {31'b0, got}, 1);
    cpu_addr = 24'h000040;
    push_exp(cyc + 2, 3, 1'b0, 1'b1, LANE_SDRAM, 1'b1, 22'h40);
    wait_ack(40, got, sel_any); cpu_req = 1'b0;
    chk("t6_got_ack2", {31'b0, got}, 1);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_region_ctrl.md
Name: mem_region_ctrl

Overview:
- Parametrised successor of the fixed 4-way SRAM/Flash/SDRAM/register decoder.
- Sits between the CPU-side memory bus and N memory/register back-ends.
- Decodes the top address bits into a one-hot region select and inserts per-region programmable wait states.
- Waits for back-end ready, with a bus timeout, then returns a single-cycle ack or error to the requester.

Parameters:
- AW, 24, CPU byte-address width.
- DW, 16, data width; must be a multiple of 8.
- RSEL_W, 2, number of top address bits used as the region index; NR = 2**RSEL_W.
- WS_W, 4, width of each per-region wait-state field.
- TO_W, 8, timeout counter width; timeout fires after 2**TO_W-1 cycles spent in WAIT_RDY.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_req  in  1  access request, level; held until cpu_ack
- cpu_we  in  1  1 = write
- cpu_be  in  DW/8  byte enables
- cpu_addr  in  AW  address
- cpu_wdata  in  DW  write data
- cpu_rdata  out  DW  read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_err  out  1  qualifies cpu_ack: disabled region or timeout
- rgn_en  in  NR  per-region enable (static config)
- ws_cfg  in  NR*WS_W  per-region wait states; field i = bits [i*WS_W +: WS_W]
- rgn_sel  out  NR  one-hot region select
- rgn_we  out  1  registered write strobe qualifier
- rgn_be  out  DW/8  registered byte enables
- rgn_addr  out  AW-RSEL_W  registered in-region offset
- rgn_wdata  out  DW  registered write data
- rgn_rdata  in  NR*DW  per-region read data
- rgn_rdy  in  NR  per-region ready

Behaviour:
- Reset: synchronous, active-high. State=IDLE; all outputs 0; counters 0. rst asserted mid-access aborts the access with no ack.
- Region index: idx = cpu_addr[AW-1 -: RSEL_W]; rgn_addr = cpu_addr[AW-RSEL_W-1:0].
- State IDLE:
  - cpu_req=1 and rgn_en[idx]=1: latch we, be, addr, wdata and idx; set rgn_sel to one-hot(idx); load ws_cnt from ws_cfg[idx]; go to ACCESS.
  - cpu_req=1 and rgn_en[idx]=0: go to DONE with err=1; rgn_sel stays 0 (no back-end access).
- State ACCESS:
  - ws_cnt != 0: decrement by 1.
  - ws_cnt == 0: clear to_cnt; go to WAIT_RDY.
  - ws_cfg = 0 therefore costs exactly one ACCESS cycle.
- State WAIT_RDY:
  - rgn_rdy[idx]=1: capture rgn_rdata[idx*DW +: DW] into the rdata register; err=0; go to DONE.
  - Otherwise increment to_cnt. When to_cnt reaches all-ones with rdy still 0: err=1, rdata=0, go to DONE.
  - If rdy and the terminal count coincide, rdy wins (no error).
- State DONE:
  - cpu_ack=1 for exactly one cycle, with cpu_err and cpu_rdata valid.
  - rgn_sel cleared to 0 on the same edge.
  - Next state IDLE.
- Latency, enabled region, rdy already high: req sampled at edge 0 → ACCESS for ws+1 cycles → WAIT_RDY 1 cycle → ack. Ack is asserted ws+3 cycles after req is first sampled.
- Disabled-region error is acked 1 cycle after req is sampled.
- Back-to-back accesses: a new request is accepted only in IDLE, so there is at least one idle cycle between acks. cpu_req still high in the cycle after ack is taken as a new request.
- cpu_addr and cpu_wdata changes after acceptance are ignored; all outputs are registered.
- cpu_rdata holds its last captured value outside ack; it is only guaranteed valid while cpu_ack=1.
- ws_cfg and rgn_en changes take effect at the next acceptance only.

Decomposition:
- Shared package mem_pkg: state enum (IDLE, ACCESS, WAIT_RDY, DONE), function onehot(idx) and a region-index extraction function. Default region map constants: REG_SDRAM=0, REG_FLASH=1, REG_SRAM=2, REG_REGS=3.
- One natural sub-module: mem_ws_timer. Holds the loadable wait-state down-counter and the timeout up-counter, with outputs ws_done and timeout.

Test Plan:
1. AW=24, ws_cfg[2]=3, rdy[2]=1; read at 0x800010 → rgn_sel=4'b0100, rgn_addr=0x000010, ack 6 cycles after req, rdata = rgn_rdata lane 2, err=0.
2. Write to 0x000004 with ws_cfg[0]=0, be=2'b10 → rgn_we=1, rgn_be=2'b10, rgn_wdata latched, ack 3 cycles after req.
3. rgn_en[1]=0; read at 0x400000 → rgn_sel never asserted, ack and err both 1 one cycle after req.
4. rdy[3] held 0; access at 0xC00000 with TO_W=4 → ack+err after 15 cycles in WAIT_RDY, rdata=0. Repeat with rdy rising on the terminal cycle → err=0.
5. rst asserted during WAIT_RDY → next cycle state IDLE, rgn_sel=0, no ack. Then a fresh request completes normally.
6. cpu_req held high over two accesses → two single-cycle acks separated by at least one cycle, with the second access using the address present at re-acceptance.
